stopwatch_ctrl: RTL and testbench

Control and sequencing block for the board stopwatch. It turns the four active-low push buttons into start / stop / clear / delayed-start commands and runs the 0.1 s tick prescaler and the 4-digit BCD count. It also runs the armed-countdown state machine. Its BCD digit outputs drive the existing per-digit 7-segment decoders (HEX3..HEX0) directly, with no divide or modulo in the display path.

---
 rtl/stopwatch_pkg.sv | 46 ++++
 rtl/stopwatch_ctrl_key_event.sv | 37 +++
 rtl/stopwatch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_RUN   = 2'b10
  } state_t;

  localparam int unsigned NUM_KEYS   = 4;
  localparam int unsigned NUM_DIGITS = 4;

  localparam int unsigned K_START = 0;
  localparam int unsigned K_STOP  = 1;
  localparam int unsigned K_CLEAR = 2;
  localparam int unsigned K_DELAY = 3;

  typedef logic [3:0] bcd_digit_t;
  typedef bcd_digit_t [NUM_DIGITS-1:0] bcd_count_t;

  typedef struct packed {
    logic       wrap;
    bcd_count_t count;
  } bcd_inc_t;

  // Decimal ripple increment; wrap is set when 9999 rolls over to 0000.
  function automatic bcd_inc_t bcd_inc(input bcd_count_t cur);
    bcd_inc_t r;
    logic     carry;
    r.count = cur;
    carry   = 1'b1;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (carry) begin
        if (cur[i] >= 4'd9) begin
          r.count[i] = 4'd0;
        end else begin
          r.count[i] = cur[i] + 4'd1;
          carry      = 1'b0;
        end
      end
    end
    r.wrap = carry;
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_key_event.sv
// Two-flop synchronizer plus falling-edge detect for one active-low key.
//   clk     : clock
//   rst_n   : async active-low reset (flops reset to released = 1)
//   key_n   : raw active-low key
//   press_c : one-cycle pulse when the synchronized key goes 1 -> 0
module key_event (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_c
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign press_c = prev_q & ~sync2_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key commands, 0.1 s prescaler, 4-digit BCD count and
// the armed-countdown FSM.
//   CLOCK_50  : clock
//   RESET_N   : async active-low reset
//   KEY       : active-low buttons [0] start [1] stop [2] clear [3] delayed start
//   bcd       : count digits, thousands in [15:12] .. units in [3:0]
//   state     : FSM state code
//   running   : high while in RUN
//   countdown : seconds left while ARMED, else 0
//   tick      : one-cycle pulse after each bcd increment
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 5_000_000,
  parameter int unsigned SEC_DIV  = 50_000_000,
  parameter int unsigned DELAY_S  = 3
) (
  input  logic                CLOCK_50,
  input  logic                RESET_N,
  input  logic [NUM_KEYS-1:0] KEY,
  output logic [15:0]         bcd,
  output logic [1:0]          state,
  output logic                running,
  output logic [3:0]          countdown,
  output logic                tick
);

  localparam int unsigned TICK_W = $clog2(TICK_DIV);
  localparam int unsigned SEC_W  = $clog2(SEC_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_DIV - 1);

  state_t            state_q,     state_d;
  bcd_count_t        bcd_q,       bcd_d;
  logic [TICK_W-1:0] tick_cnt_q,  tick_cnt_d;
  logic [SEC_W-1:0]  sec_cnt_q,   sec_cnt_d;
  logic [3:0]        countdown_q, countdown_d;
  logic              tick_q,      tick_d;
  logic              running_q,   running_d;

  logic [NUM_KEYS-1:0] press_c;
  logic                clr_c, stop_c, start_c, delay_c;
  logic                tick_last_c;
  bcd_inc_t            inc_c;

  // One edge-detected event per key
  for (genvar g = 0; g < int'(NUM_KEYS); g++) begin : g_key
    key_event u_key_event (
      .clk     (CLOCK_50),
      .rst_n   (RESET_N),
      .key_n   (KEY[g]),
      .press_c (press_c[g])
    );
  end

  // Priority: clear > stop > start > delayed start
  assign clr_c   = press_c[K_CLEAR];
  assign stop_c  = press_c[K_STOP]  & ~clr_c;
  assign start_c = press_c[K_START] & ~press_c[K_STOP] & ~clr_c;
  assign delay_c = press_c[K_DELAY] & ~press_c[K_START] & ~press_c[K_STOP] & ~clr_c;

  assign tick_last_c = (tick_cnt_q == TICK_LAST);
  assign inc_c       = bcd_inc(bcd_q);

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    tick_cnt_d  = tick_cnt_q;
    sec_cnt_d   = sec_cnt_q;
    countdown_d = countdown_q;
    tick_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d    = ST_RUN;
          tick_cnt_d = '0;
        end else if (delay_c) begin
          state_d     = ST_ARMED;
          countdown_d = 4'(DELAY_S);
          sec_cnt_d   = '0;
        end
      end

      ST_ARMED: begin
        if (stop_c) begin
          state_d     = ST_IDLE;
          countdown_d = 4'd0;
        end else if (start_c) begin
          state_d     = ST_RUN;
          countdown_d = 4'd0;
          tick_cnt_d  = '0;
        end else if (sec_cnt_q == SEC_LAST) begin
          sec_cnt_d = '0;
          if (countdown_q <= 4'd1) begin
            state_d     = ST_RUN;
            countdown_d = 4'd0;
            tick_cnt_d  = '0;
          end else begin
            countdown_d = countdown_q - 4'd1;
          end
        end else begin
          sec_cnt_d = sec_cnt_q + SEC_W'(1);
        end
      end

      ST_RUN: begin
        // A terminal count still increments when stop lands on the same cycle
        if (tick_last_c) begin
          tick_cnt_d = '0;
          bcd_d      = inc_c.count;
          tick_d     = 1'b1;
          if (inc_c.wrap) begin
            state_d = ST_IDLE;
          end
        end else if (!stop_c) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
        end
        if (stop_c) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        countdown_d = 4'd0;
      end
    endcase

    // Clear overrides any increment but leaves state and countdown alone
    if (clr_c) begin
      bcd_d      = '0;
      tick_cnt_d = '0;
      tick_d     = 1'b0;
    end

    running_d = (state_d == ST_RUN);
  end

  // State register
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      bcd_q       <= '0;
      tick_cnt_q  <= '0;
      sec_cnt_q   <= '0;
      countdown_q <= 4'd0;
      tick_q      <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcd_q       <= bcd_d;
      tick_cnt_q  <= tick_cnt_d;
      sec_cnt_q   <= sec_cnt_d;
      countdown_q <= countdown_d;
      tick_q      <= tick_d;
      running_q   <= running_d;
    end
  end

  assign bcd       = bcd_q;
  assign state     = state_q;
  assign running   = running_q;
  assign countdown = countdown_q;
  assign tick      = tick_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a scoreboard of expected snapshots.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [3:0]  key;
  logic [15:0] bcd;
  logic [1:0]  state;
  logic        running;
  logic [3:0]  countdown;
  logic        tick;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [23:0] val;
  } exp_t;

  exp_t sb_q[$];

  stopwatch_ctrl #(
    .TICK_DIV (4),
    .SEC_DIV  (10),
    .DELAY_S  (3)
  ) dut (
    .CLOCK_50  (clk),
    .RESET_N   (rst_n),
    .KEY       (key),
    .bcd       (bcd),
    .state     (state),
    .running   (running),
    .countdown (countdown),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the edge
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a press of the masked keys; returns just after the edge where it acts
  task automatic press(input logic [3:0] mask);
    key = ~mask;
    step(1);
    key = 4'hF;
    step(2);
  endtask

  task automatic expect_snap(input string tag, input logic [1:0] st, input logic run,
                             input logic tk, input logic [3:0] cd, input logic [15:0] b);
    exp_t e;
    e.tag = tag;
    e.val = {st, run, tk, cd, b};
    sb_q.push_back(e);
  endtask

  task automatic check_snap();
    exp_t        e;
    logic [23:0] obs;
    obs = {state, running, tick, countdown, bcd};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%06h required=<none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%06h required=%06h", e.tag, obs, e.val);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key   = 4'hF;

    // Reset values
    expect_snap("reset", ST_IDLE, 1'b0, 1'b0, 4'd0, 16'h0000);
    step(3);
    check_snap();
    @(negedge clk);
    rst_n = 1'b1;
    step(1);

    // Start: running two edges after first sample, bcd 0001 four edges later
    expect_snap("start_run", ST_RUN, 1'b1, 1'b0, 4'd0, 16'h0000);
    press(4'b0001);
    check_snap();
    expect_snap("first_inc", ST_RUN, 1'b1, 1'b1, 4'd0, 16'h0001);
    step(4);
    check_snap();
    expect_snap("tick_low", ST_RUN, 1'b1, 1'b0, 4'd0, 16'h0001);
    step(1);
    check_snap();
    expect_snap("run_40", ST_RUN, 1'b1, 1'b1, 4'd0, 16'h0010);
    step(35);
    check_snap();

    // Run up to 9998, then the 9999 -> 0000 wrap returns to IDLE
    expect_snap("at_9998", ST_RUN, 1'b1, 1'b1, 4'd0, 16'h9998);
    step(9988 * 4);
    check_snap();
    expect_snap("at_9999", ST_RUN, 1'b1, 1'b1, 4'd0, 16'h9999);
    step(4);
    check_snap();
    expect_snap("wrap_idle", ST_IDLE, 1'b0, 1'b1, 4'd0, 16'h0000);
    step(4);
    check_snap();

    // Delayed start countdown
    expect_snap("armed", ST_ARMED, 1'b0, 1'b0, 4'd3, 16'h0000);
    press(4'b1000);
    check_snap();
    expect_snap("cd_2", ST_ARMED, 1'b0, 1'b0, 4'd2, 16'h0000);
    step(10);
    check_snap();
    expect_snap("cd_1", ST_ARMED, 1'b0, 1'b0, 4'd1, 16'h0000);
    step(10);
    check_snap();
    expect_snap("cd_run", ST_RUN, 1'b1, 1'b0, 4'd0, 16'h0000);
    step(10);
    check_snap();
    expect_snap("cd_first_inc", ST_RUN, 1'b1, 1'b1, 4'd0, 16'h0001);
    step(4);
    check_snap();

    // Stop + clear together on a tick terminal: clear wins, no increment
    step(1);
    expect_snap("clear_wins", ST_RUN, 1'b1, 1'b0, 4'd0, 16'h0000);
    press(4'b0110);
    check_snap();
    expect_snap("clear_restart", ST_RUN, 1'b1, 1'b1, 4'd0, 16'h0001);
    step(4);
    check_snap();
    expect_snap("after_clear_2", ST_RUN, 1'b1, 1'b1, 4'd0, 16'h0002);
    step(4);
    check_snap();

    // Stop on a tick terminal: IDLE and the increment still happens
    step(1);
    expect_snap("stop_on_term", ST_IDLE, 1'b0, 1'b1, 4'd0, 16'h0003);
    press(4'b0010);
    check_snap();
    expect_snap("idle_hold", ST_IDLE, 1'b0, 1'b0, 4'd0, 16'h0003);
    step(8);
    check_snap();

    // Stop while ARMED with countdown = 2
    expect_snap("armed_2", ST_ARMED, 1'b0, 1'b0, 4'd3, 16'h0003);
    press(4'b1000);
    check_snap();
    expect_snap("armed_cd2", ST_ARMED, 1'b0, 1'b0, 4'd2, 16'h0003);
    step(10);
    check_snap();
    expect_snap("armed_stop", ST_IDLE, 1'b0, 1'b0, 4'd0, 16'h0003);
    press(4'b0010);
    check_snap();

    // Asynchronous reset in the middle of RUN
    expect_snap("rerun", ST_RUN, 1'b1, 1'b0, 4'd0, 16'h0003);
    press(4'b0001);
    check_snap();
    expect_snap("rerun_inc", ST_RUN, 1'b1, 1'b0, 4'd0, 16'h0004);
    step(5);
    check_snap();
    #5;
    expect_snap("async_reset", ST_IDLE, 1'b0, 1'b0, 4'd0, 16'h0000);
    rst_n = 1'b0;
    #1;
    check_snap();

    // Key held low through reset release gives exactly one start
    key = 4'b1110;
    @(negedge clk);
    rst_n = 1'b1;
    expect_snap("held_start", ST_RUN, 1'b1, 1'b0, 4'd0, 16'h0000);
    step(3);
    check_snap();
    expect_snap("held_stop", ST_IDLE, 1'b0, 1'b0, 4'd0, 16'h0000);
    key = 4'b1100;
    step(1);
    key = 4'b1110;
    step(2);
    check_snap();
    expect_snap("held_no_restart", ST_IDLE, 1'b0, 1'b0, 4'd0, 16'h0000);
    step(10);
    check_snap();
    key = 4'hF;

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d required=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
